elevator_call_scheduler: RTL and testbench

//  Upstream stage of the elevator controller: synchronises and debounces the four floor call buttons.

---
 rtl/elevator_pkg.sv | 33 +++
 rtl/elevator_call_scheduler_if.sv | 31 +++
 rtl/call_debounce.sv | 47 ++++
 rtl/elevator_call_scheduler.sv | 138 +++++++++++++
 tb/tb_elevator_call_scheduler.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================
// Package : elevator_pkg
// Shared floor indices, FSM encoding and helpers.
// Rev     : 1.0
// ============================================================
package elevator_pkg;

  localparam int N_FLOORS = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_FIRE = 2'd3;

  localparam logic [1:0] FLOOR_G = 2'd0;
  localparam logic [1:0] FLOOR_1 = 2'd1;
  localparam logic [1:0] FLOOR_2 = 2'd2;
  localparam logic [1:0] FLOOR_3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_UP   = S_UP,
    ST_DOWN = S_DOWN,
    ST_FIRE = S_FIRE
  } state_t;

  function automatic logic [N_FLOORS-1:0] floor_onehot(input logic [1:0] f);
    return N_FLOORS'(1) << f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_call_scheduler_if.sv
`default_nettype none
// ============================================================
// Interface : elevator_call_scheduler_if
// Call inputs, controller status and request outputs.
// Rev       : 1.0
// ============================================================
interface elevator_call_scheduler_if;
  logic [3:0] btn;
  logic [3:0] bcd_floor;
  logic       door_open;
  logic       firealarm;
  logic       overload;
  logic       reqG;
  logic       reqF1;
  logic       reqF2;
  logic       reqF3;
  logic [3:0] pending;
  logic       dir_up;
  logic       bad_floor;

  modport master (
    output btn, bcd_floor, door_open, firealarm, overload,
    input  reqG, reqF1, reqF2, reqF3, pending, dir_up, bad_floor
  );

  modport slave (
    input  btn, bcd_floor, door_open, firealarm, overload,
    output reqG, reqF1, reqF2, reqF3, pending, dir_up, bad_floor
  );
endinterface
`default_nettype wire

// File: rtl/call_debounce.sv
`default_nettype none
// ============================================================
// Module : call_debounce
// 2-flop synchroniser, saturating debounce counter, press pulse.
// Rev    : 1.0
// ============================================================
module call_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [DB_W-1:0] c_max = DB_W'(DB_CYCLES);
  localparam logic [DB_W-1:0] c_pre = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] c_one = DB_W'(1);

  logic            r_sync1;
  logic            r_sync2;
  logic [DB_W-1:0] r_cnt;
  logic            r_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (!r_sync2)
        r_cnt <= '0;
      else if (r_cnt != c_max)
        r_cnt <= r_cnt + c_one;
      // Fires only on the transition into saturation, so a held button yields one event.
      r_press <= r_sync2 && (r_cnt == c_pre);
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/elevator_call_scheduler.sv
`default_nettype none
// ============================================================
// Module : elevator_call_scheduler
// Debounces floor calls, latches them and issues SCAN-ordered requests.
// Rev    : 1.0
// ============================================================
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 3
) (
  input logic                      clk,
  input logic                      rst,
  elevator_call_scheduler_if.slave bus
);

  logic [N_FLOORS-1:0] w_press;
  logic [N_FLOORS-1:0] r_pending;
  logic [N_FLOORS-1:0] r_req;
  logic [N_FLOORS-1:0] w_req_n;
  logic [N_FLOORS-1:0] w_clr;
  state_t              r_state;
  state_t              w_state_n;
  logic                r_dir_up;
  logic                r_bad_floor;
  logic [1:0]          w_cf;
  logic                w_bad;
  logic                w_has_up;
  logic                w_has_dn;
  logic [1:0]          w_up_tgt;
  logic [1:0]          w_dn_tgt;
  logic [1:0]          w_dist_up;
  logic [1:0]          w_dist_dn;
  logic                w_go_up;
  logic [1:0]          w_tgt;

  for (genvar g = 0; g < N_FLOORS; g++) begin : g_btn
    call_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (bus.btn[g]),
      .o_press (w_press[g])
    );
  end

  assign w_cf  = bus.bcd_floor[1:0];
  assign w_bad = |bus.bcd_floor[3:2];
  assign w_clr = (bus.door_open && !w_bad) ? floor_onehot(w_cf) : '0;

  // Nearest pending floor at/above and at/below the car.
  always_comb begin
    w_has_up = 1'b0;
    w_has_dn = 1'b0;
    w_up_tgt = '0;
    w_dn_tgt = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && (i >= int'(w_cf))) begin
        w_has_up = 1'b1;
        w_up_tgt = 2'(i);
      end
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (r_pending[i] && (i <= int'(w_cf))) begin
        w_has_dn = 1'b1;
        w_dn_tgt = 2'(i);
      end
    end
    w_dist_up = w_up_tgt - w_cf;
    w_dist_dn = w_cf - w_dn_tgt;
  end

  always_comb begin
    w_state_n = r_state;
    w_req_n   = r_req;
    w_go_up   = 1'b1;
    case (r_state)
      ST_IDLE: w_go_up = w_has_up && (!w_has_dn || (w_dist_up <= w_dist_dn));
      ST_UP:   w_go_up = w_has_up;
      ST_DOWN: w_go_up = !w_has_dn;
      default: w_go_up = 1'b1;
    endcase
    w_tgt = w_go_up ? w_up_tgt : w_dn_tgt;

    if (bus.firealarm) begin
      w_state_n = ST_FIRE;
      w_req_n   = floor_onehot(FLOOR_G);
    end else if (r_state == ST_FIRE) begin
      // Leaving recall keeps reqG for one more cycle while IDLE re-evaluates.
      w_state_n = ST_IDLE;
      w_req_n   = floor_onehot(FLOOR_G);
    end else if (bus.overload || w_bad) begin
      w_state_n = r_state;
      w_req_n   = r_req;
    end else if (r_pending == '0) begin
      w_state_n = ST_IDLE;
      w_req_n   = '0;
    end else begin
      w_state_n = w_go_up ? ST_UP : ST_DOWN;
      w_req_n   = floor_onehot(w_tgt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_pending   <= '0;
      r_dir_up    <= 1'b1;
      r_bad_floor <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_req       <= w_req_n;
      r_bad_floor <= w_bad;
      if (bus.firealarm)
        r_pending <= '0;
      else
        r_pending <= (r_pending | w_press) & ~w_clr;
      if (w_state_n == ST_UP)
        r_dir_up <= 1'b1;
      else if (w_state_n == ST_DOWN)
        r_dir_up <= 1'b0;
    end
  end

  assign bus.reqG      = r_req[FLOOR_G];
  assign bus.reqF1     = r_req[FLOOR_1];
  assign bus.reqF2     = r_req[FLOOR_2];
  assign bus.reqF3     = r_req[FLOOR_3];
  assign bus.pending   = r_pending;
  assign bus.dir_up    = r_dir_up;
  assign bus.bad_floor = r_bad_floor;

endmodule
`default_nettype wire

// File: tb/tb_elevator_call_scheduler.sv
`default_nettype none
// ============================================================
// Module : tb_elevator_call_scheduler
// Vector table plus hand sequences for the call scheduler.
// Rev    : 1.0
// ============================================================
module tb_elevator_call_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  elevator_call_scheduler_if bus();

  elevator_call_scheduler #(
    .DB_CYCLES (4),
    .DB_W      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] btn;
    logic [3:0] cf;
    logic       door;
    logic       fire;
    logic       ovl;
    int         cyc;
    logic [3:0] pend;
    logic [3:0] req;
    logic       dir;
    logic       bad;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] pend;
    logic [3:0] req;
    logic       dir;
    logic       bad;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic [3:0] btn, logic [3:0] cf, logic door, logic fire,
                              logic ovl, int cyc, logic [3:0] pend, logic [3:0] req,
                              logic dir, logic bad);
    vec_t v;
    v.btn = btn; v.cf = cf; v.door = door; v.fire = fire; v.ovl = ovl;
    v.cyc = cyc; v.pend = pend; v.req = req; v.dir = dir; v.bad = bad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] req_vec();
    return {bus.reqF3, bus.reqF2, bus.reqF1, bus.reqG};
  endfunction

  task automatic drive(input logic [3:0] btn, input logic [3:0] cf, input logic door,
                       input logic fire, input logic ovl);
    bus.btn       = btn;
    bus.bcd_floor = cf;
    bus.door_open = door;
    bus.firealarm = fire;
    bus.overload  = ovl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    drive(4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
    step(2);
    rst = 1'b0;
    chk("reset.pend", bus.pending, 4'b0000);
    chk("reset.req",  req_vec(),   4'b0000);
    chk("reset.dir",  {3'b0, bus.dir_up},    4'b0001);
    chk("reset.bad",  {3'b0, bus.bad_floor}, 4'b0000);

    //                 btn      cf  door fire ovl cyc pend     req      dir  bad
    // F3 call from ground, then cleared at floor 3
    vecs.push_back(mk(4'b1000, 0, 0, 0, 0, 6, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(4'b1000, 0, 0, 0, 0, 1, 4'b1000, 4'b0000, 1, 0));
    vecs.push_back(mk(4'b1000, 0, 0, 0, 0, 1, 4'b1000, 4'b1000, 1, 0));
    vecs.push_back(mk(4'b0000, 3, 1, 0, 0, 1, 4'b0000, 4'b1000, 1, 0));
    vecs.push_back(mk(4'b0000, 3, 0, 0, 0, 1, 4'b0000, 4'b0000, 1, 0));
    // SCAN with tie at floor 1, then reversal to ground
    vecs.push_back(mk(4'b0101, 1, 0, 0, 0, 7, 4'b0101, 4'b0000, 1, 0));
    vecs.push_back(mk(4'b0101, 1, 0, 0, 0, 1, 4'b0101, 4'b0100, 1, 0));
    vecs.push_back(mk(4'b0000, 2, 1, 0, 0, 1, 4'b0001, 4'b0100, 1, 0));
    vecs.push_back(mk(4'b0000, 2, 0, 0, 0, 1, 4'b0001, 4'b0001, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 0, 1, 4'b0000, 4'b0001, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0));
    // Press landing on the same edge as door-open at that floor; held button re-fires never
    vecs.push_back(mk(4'b0010, 1, 0, 0, 0, 6, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0010, 1, 1, 0, 0, 1, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0010, 1, 0, 0, 0, 4, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 0, 0, 3, 4'b0000, 4'b0000, 0, 0));
    // Fire recall
    vecs.push_back(mk(4'b1010, 0, 0, 0, 0, 7, 4'b1010, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b1010, 0, 0, 0, 0, 1, 4'b1010, 4'b0010, 1, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 1, 0, 1, 4'b0000, 4'b0001, 1, 0));
    vecs.push_back(mk(4'b0100, 0, 0, 1, 0, 8, 4'b0000, 4'b0001, 1, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 4'b0000, 4'b0001, 1, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 1, 0));
    // Overload hold, then bad floor
    vecs.push_back(mk(4'b0100, 1, 0, 0, 0, 7, 4'b0100, 4'b0000, 1, 0));
    vecs.push_back(mk(4'b0100, 1, 0, 0, 0, 1, 4'b0100, 4'b0100, 1, 0));
    vecs.push_back(mk(4'b1000, 1, 0, 0, 1, 8, 4'b1100, 4'b0100, 1, 0));
    vecs.push_back(mk(4'b0000, 2, 1, 0, 1, 1, 4'b1000, 4'b0100, 1, 0));
    vecs.push_back(mk(4'b0000, 2, 0, 0, 1, 2, 4'b1000, 4'b0100, 1, 0));
    vecs.push_back(mk(4'b0000, 2, 0, 0, 0, 1, 4'b1000, 4'b1000, 1, 0));
    vecs.push_back(mk(4'b0000, 5, 0, 0, 0, 1, 4'b1000, 4'b1000, 1, 1));
    vecs.push_back(mk(4'b0000, 3, 0, 0, 0, 1, 4'b1000, 4'b1000, 1, 0));
    vecs.push_back(mk(4'b0000, 3, 1, 0, 0, 1, 4'b0000, 4'b1000, 1, 0));
    vecs.push_back(mk(4'b0000, 3, 0, 0, 0, 1, 4'b0000, 4'b0000, 1, 0));

    foreach (vecs[k]) begin
      drive(vecs[k].btn, vecs[k].cf, vecs[k].door, vecs[k].fire, vecs[k].ovl);
      e.idx = k; e.pend = vecs[k].pend; e.req = vecs[k].req;
      e.dir = vecs[k].dir; e.bad = vecs[k].bad;
      sb.push_back(e);
      step(vecs[k].cyc);
      e = sb.pop_front();
      chk($sformatf("v%0d.pend", e.idx), bus.pending, e.pend);
      chk($sformatf("v%0d.req",  e.idx), req_vec(),   e.req);
      chk($sformatf("v%0d.dir",  e.idx), {3'b0, bus.dir_up},    {3'b0, e.dir});
      chk($sformatf("v%0d.bad",  e.idx), {3'b0, bus.bad_floor}, {3'b0, e.bad});
    end

    // Bounce: toggling every cycle never reaches the debounce threshold
    drive(4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.btn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      step(1);
    end
    bus.btn = 4'b0000;
    step(6);
    chk("bounce.pend", bus.pending, 4'b0000);
    chk("bounce.req",  req_vec(),   4'b0000);

    // Three clean cycles: one short of acceptance
    bus.btn = 4'b0010;
    step(3);
    bus.btn = 4'b0000;
    step(6);
    chk("pulse3.pend", bus.pending, 4'b0000);

    // Four clean cycles: exactly accepted
    bus.btn = 4'b0010;
    step(4);
    bus.btn = 4'b0000;
    step(6);
    chk("pulse4.pend", bus.pending, 4'b0010);
    chk("pulse4.req",  req_vec(),   4'b0010);

    // Car above the only call: UP finds nothing ahead and turns DOWN
    bus.bcd_floor = 4'd3;
    step(2);
    chk("turn.req", req_vec(),             4'b0010);
    chk("turn.dir", {3'b0, bus.dir_up},    4'b0000);

    // Asynchronous reset mid-operation drops the call
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.pend", bus.pending,         4'b0000);
    chk("midrst.req",  req_vec(),           4'b0000);
    chk("midrst.dir",  {3'b0, bus.dir_up},  4'b0001);
    step(2);
    rst = 1'b0;
    step(10);
    chk("postrst.pend", bus.pending, 4'b0000);
    chk("postrst.req",  req_vec(),   4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
